// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage port: one outstanding load/store,
// served after a fixed access latency, with the word array cleared after every reset.
module dmem_responder #(
   parameter int ADDR_W  = 6,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
   localparam logic [3:0]        CNT_INIT = 4'(LATENCY-1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              reqReady_q, reqReady_d;
   logic              rspValid_q, rspValid_d;
   logic [31:0]       rspRdata_q, rspRdata_d;
   logic              rspErr_q, rspErr_d;
   logic              busy_q, busy_d;

   logic [31:0]       mem [DEPTH];
   logic              memWe;
   logic [ADDR_W-1:0] memIdx;
   logic [31:0]       memData;
   logic [3:0]        memBe;
   logic              inRange;

   assign inRange = ({1'b0, addr_q} < DEPTH_W);

   always_comb begin
      state_d    = state_q;
      clrIdx_d   = clrIdx_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rspValid_d = rspValid_q;
      rspRdata_d = rspRdata_q;
      rspErr_d   = rspErr_q;
      memWe      = 1'b0;
      memIdx     = addr_q;
      memData    = wdata_q;
      memBe      = be_q;
      case (state_q)
         CLEAR: begin
            memWe    = 1'b1;
            memIdx   = clrIdx_q;
            memData  = '0;
            memBe    = 4'hF;
            clrIdx_d = clrIdx_q + 1'b1;
            if (clrIdx_q == LAST_IDX) begin
               state_d  = IDLE;
               clrIdx_d = '0;
            end
         end
         IDLE: begin
            if (req_valid && reqReady_q) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // The access itself happens on the edge that leaves WAIT, so the
            // store is complete before its response can be observed.
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               rspValid_d = 1'b1;
               rspErr_d   = !inRange;
               rspRdata_d = (!we_q && inRange) ? mem[addr_q] : 32'd0;
               memWe      = we_q && inRange;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d    = IDLE;
               rspValid_d = 1'b0;
               rspErr_d   = 1'b0;
            end
         end
         default: state_d = CLEAR;
      endcase
      reqReady_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= CLEAR;
         clrIdx_q   <= '0;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         reqReady_q <= 1'b0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clrIdx_q   <= clrIdx_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         reqReady_q <= reqReady_d;
         rspValid_q <= rspValid_d;
         rspRdata_q <= rspRdata_d;
         rspErr_q   <= rspErr_d;
         busy_q     <= busy_d;
      end
   end

   // The array has no reset; CLEAR zeroes it word by word instead.
   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int i = 0; i < 4; i++) begin
            if (memBe[i]) mem[memIdx][8*i +: 8] <= memData[8*i +: 8];
         end
      end
   end

   assign req_ready = reqReady_q;
   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;
   assign busy      = busy_q;

endmodule
